// File: rtl/bcd_display_mux_if.sv
// Display bus between a BCD source and the digit-scanning mux: value/enable in, anode/segment pins out.
interface bcd_display_mux_if #(
    parameter int Ndigit = 4
);
    logic                  en;
    logic [Ndigit*4-1:0]   BCD;
    logic [Ndigit-1:0]     anode;
    logic [6:0]            seg;
    logic                  dp;

    modport master (output en, BCD, input anode, seg, dp);
    modport slave  (input en, BCD, output anode, seg, dp);
endinterface

// File: rtl/bcd_display_mux.sv
// Time-multiplexed common-anode 7-segment driver with per-frame BCD snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_display_mux #(
    parameter int Ndigit   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_display_mux_if.slave   bus
);

    localparam int IW = (Ndigit > 1) ? $clog2(Ndigit) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0]          scan_cnt;
    logic [IW-1:0]          digit_idx;
    logic [Ndigit*4-1:0]    frame;
    logic                   tick;
    logic                   frame_end;

    logic [3:0]             cur_digit;
    logic                   cur_blank;
    logic [Ndigit-1:0]      lz_blank;
    logic [Ndigit-1:0]      anode_d;
    logic [6:0]             seg_d;
    logic [Ndigit-1:0]      anode_q;
    logic [6:0]             seg_q;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick      = (scan_cnt == CW'(SCAN_DIV - 1));
    assign frame_end = tick && (digit_idx == IW'(Ndigit - 1));

    // Counter, index and snapshot run regardless of en so re-enabling never slips phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            frame     <= '0;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + CW'(1);
            if (tick) begin
                digit_idx <= frame_end ? '0 : digit_idx + IW'(1);
            end
            if (frame_end) begin
                frame <= bus.BCD;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero; digit 0 is exempt.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int k = Ndigit - 1; k >= 0; k--) begin
            all_zero    = all_zero && (frame[4*k +: 4] == 4'd0);
            lz_blank[k] = (k != 0) && all_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < Ndigit; i++) begin
            if (digit_idx == IW'(i)) begin
                cur_digit = frame[4*i +: 4];
                cur_blank = lz_blank[i];
            end
        end
    end

    always_comb begin
        anode_d = '1;
        seg_d   = 7'b1111111;
        if (bus.en && !cur_blank) begin
            for (int i = 0; i < Ndigit; i++) begin
                anode_d[i] = (digit_idx != IW'(i));
            end
            seg_d = decode(cur_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_q <= '1;
            seg_q   <= 7'b1111111;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.anode = anode_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = 1'b1;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: directed scenarios plus random BCD/en traffic against a cycle-count model.
module tb_bcd_display_mux;

    localparam int N = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_display_mux_if #(.Ndigit(N)) bus ();

    bcd_display_mux #(.Ndigit(N), .SCAN_DIV(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    int               m_n = 0;
    logic [N*4-1:0]   m_frame = '0;
    logic [N-1:0]     m_anode = '1;
    logic [6:0]       m_seg = 7'b1111111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Model: after n edges since reset the slot shown is ((n-1)/S)%N; frames load every N*S edges.
    initial begin
        logic            r, e;
        logic [N*4-1:0]  b;
        int              idx;
        logic [3:0]      dig;
        logic            blank;
        forever begin
            @(posedge clk);
            r = rst;
            e = bus.en;
            b = bus.BCD;
            if (r) begin
                m_n     = 0;
                m_frame = '0;
                m_anode = '1;
                m_seg   = 7'b1111111;
            end else begin
                m_n++;
                idx   = ((m_n - 1) / S) % N;
                dig   = 4'((m_frame >> (4 * idx)) & 'hF);
                blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (idx != 0) && ((m_frame >> (4 * idx)) == 0);
`endif
                if (e && !blank) begin
                    m_anode = ~(N'(1) << idx);
                    m_seg   = seg_tab[dig];
                end else begin
                    m_anode = '1;
                    m_seg   = 7'b1111111;
                end
                if (m_n % (S * N) == 0) m_frame = b;
            end
            #1;
            check("anode", 32'(bus.anode), 32'(m_anode));
            check("seg", 32'(bus.seg), 32'(m_seg));
            check("dp", 32'(bus.dp), 32'd1);
            check("onehot", 32'($countones(~bus.anode) <= 1), 32'd1);
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [N-1:0] a, input logic [6:0] s);
        check({name, "_anode"}, 32'(bus.anode), 32'(a));
        check({name, "_seg"}, 32'(bus.seg), 32'(s));
    endtask

    initial begin
        bus.en  = 1'b1;
        bus.BCD = '0;
        rst     = 1'b1;
        step(3);
        lit("reset", 4'b1111, 7'b1111111);

        rst     = 1'b0;
        bus.BCD = 16'h1234;
        step(1);  lit("first_slot", 4'b1110, 7'b1000000);
        step(16); lit("frame1_d0", 4'b1110, 7'b0011001);
        step(4);  lit("frame1_d1", 4'b1101, 7'b0110000);

        step(4);  bus.BCD = 16'h0042;
        step(27); bus.BCD = 16'h9999;
        step(2);  lit("tear_d1", 4'b1101, 7'b0011001);
        step(7);
`ifdef LEADING_ZERO_BLANK_EN
        lit("tear_d3", 4'b1111, 7'b1111111);
`else
        lit("tear_d3", 4'b0111, 7'b1000000);
`endif
        step(4);  lit("tear_new", 4'b1110, 7'b0010000);

        bus.BCD = 16'hAB5C;
        step(16); lit("inv_d0", 4'b1110, 7'b0111111);
        step(4);  lit("inv_d1", 4'b1101, 7'b0010010);

        step(5);  bus.en = 1'b0;
        step(1);  lit("en_off", 4'b1111, 7'b1111111);
        step(9);  bus.en = 1'b1;
        step(1);  lit("en_back", 4'b1101, 7'b0010010);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int d = 0; d < N; d++)
                    bus.BCD[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            step(1);
        end
        bus.en = 1'b1;

        for (int i = 0; i < 32; i++) begin
            if (m_n % (S * N) == 9) break;
            step(1);
        end
        check("midreset_phase", 32'(m_n % (S * N)), 32'd9);
        rst = 1'b1;
        step(1);  lit("midreset", 4'b1111, 7'b1111111);

        rst     = 1'b0;
        bus.BCD = 16'h0070;
        step(1);  lit("post_reset", 4'b1110, 7'b1000000);
        step(20); lit("lz_d1", 4'b1101, 7'b1111000);
        step(4);
`ifdef LEADING_ZERO_BLANK_EN
        lit("lz_d2", 4'b1111, 7'b1111111);
`else
        lit("lz_d2", 4'b1011, 7'b1000000);
`endif
        step(15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
